alu_issue: RTL
==============

Name: alu_issue

Overview:
- Execute-stage front end that sits in front of the combinational 64-bit ALU (sum/and/xor enables, carry-in, C/V/Z out).
- Accepts integer ops over a valid/ready request channel and drives the ALU operand and control inputs.
- Captures the ALU result and flags, then returns them over a valid/ready response channel.
- Two-stage pipeline with backpressure; holds a sticky carry register for multi-word ADDC/SUBC chains.

Parameters:
- XLEN, 64, datapath width; must match the ALU width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  4  opcode: 0 ADD, 1 SUB, 2 ADDC, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 SLT, 8 SLTU; 9-15 illegal
- req_a_i  in  XLEN  operand A
- req_b_i  in  XLEN  operand B
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  XLEN  result
- rsp_flags_o  out  3  {C,V,Z} from the ALU for this op
- rsp_err_o  out  1  illegal opcode
- alu_inA_o  out  XLEN  ALU operand A
- alu_inB_o  out  XLEN  ALU operand B
- alu_cflag_o  out  1  ALU carry-in
- alu_sum_en_o, alu_and_en_o, alu_xor_en_o  out  1 each  ALU enables
- alu_out_i  in  XLEN  ALU result
- alu_cflag_i, alu_vflag_i, alu_zflag_i  in  1 each  ALU flags

Behaviour:
- Reset (reset_i low, asynchronous): both stage valids = 0; carry_q = 0; rsp_valid_o = 0; rsp_data_o = 0; rsp_flags_o = 0; rsp_err_o = 0. All ALU-drive outputs are 0 while S1 is empty.
- Reset asserted mid-operation discards every in-flight op. No response is produced for them.
- S1 (operand register): loads op, A and B on req_valid_i && req_ready_o. ALU outputs are driven combinationally from S1.
- S2 (response register): loads from the ALU when S1 advances. It drives the rsp_* outputs.
- req_ready_o = !s1_valid || s1_adv.
- s1_adv = s1_valid && (!s2_valid || rsp_ready_i).
- Latency: an op accepted at edge N is presented on rsp_valid_o after edge N+1. Throughput is 1 op/cycle when rsp_ready_i is held high.
- rsp_* outputs stay stable while rsp_valid_o && !rsp_ready_i.
- ALU control mapping:
  - ADD: sum, cin = 0.
  - SUB: sum, B inverted, cin = 1.
  - ADDC: sum, cin = carry_q.
  - SUBC: sum, B inverted, cin = carry_q.
  - AND: and only.
  - OR: and + xor (the ALU ORs the two outputs).
  - XOR: xor only.
  - SLT/SLTU: same drive as SUB.
- Result: alu_out_i for every op except the following.
  - SLT: zero-extended (alu_out_i[XLEN-1] ^ alu_vflag_i).
  - SLTU: zero-extended (!alu_cflag_i).
- carry_q updates to alu_cflag_i on s1_adv for ADD, SUB, ADDC, SUBC only. All other ops leave it unchanged.
- carry_q updates in the same cycle the op leaves S1, so a back-to-back ADDC sees its predecessor's carry with no bubble.
- Carry convention: C = 1 means no borrow.
- Illegal opcode: all ALU enables 0, rsp_data_o = 0, rsp_err_o = 1, carry_q unchanged.
- Simultaneous events: accept, advance and drain in the same cycle are all legal. A full pipe with rsp_ready_i high accepts a new op every cycle.

Optional Feature:
- Macro: ALU_ISSUE_SLT_EN.
- Defined: opcodes 7 and 8 implement SLT/SLTU as above.
- Undefined: opcodes 7 and 8 are treated as illegal (rsp_err_o = 1, data 0) and the compare logic is not built.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode enum (ALU_OP_ADD..ALU_OP_SLTU);
  - the flag bit index constants FLAG_C = 2, FLAG_V = 1, FLAG_Z = 0;
  - the XLEN default.
- One natural sub-module: alu_issue_decode. It is combinational and maps the opcode to {sum_en, and_en, xor_en, invert_b, cin_sel, carry_upd, illegal}.

Test Plan:
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1, then ADDC 0 + 0 back-to-back:
  - first response: data 0, C = 1, Z = 1;
  - second response: data 1 (carry chained with no bubble).
- SUB 5 - 7: data 0xFFFF_FFFF_FFFF_FFFE, C = 0. Then SUBC 10 - 3: data 6.
- OR 0xF0 | 0x0F: data 0xFF, alu_and_en_o = alu_xor_en_o = 1 while in S1. XOR 0xFF ^ 0x0F: data 0xF0. carry_q unchanged.
- With ALU_ISSUE_SLT_EN defined:
  - SLT 0x8000_0000_0000_0000 vs 1: data 1;
  - SLTU with the same operands: data 0.
- Without ALU_ISSUE_SLT_EN: op 7 gives rsp_err_o = 1, data 0.
- Backpressure: hold rsp_ready_i low and issue 3 ops.
  - Exactly 2 are accepted; req_ready_o goes low.
  - Responses hold stable.
  - Release rsp_ready_i: all 3 come out in order.
- Reset: pull reset_i low with 2 ops in flight.
  - Outputs go to 0 asynchronously.
  - No stale response appears after release.
  - carry_q = 0 (verified by ADDC 0 + 0 = 0).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, flag bit positions,
// carry-in selector encodings and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEF = 64;

    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_ADDC = 4'd2,
        ALU_OP_SUBC = 4'd3,
        ALU_OP_AND  = 4'd4,
        ALU_OP_OR   = 4'd5,
        ALU_OP_XOR  = 4'd6,
        ALU_OP_SLT  = 4'd7,
        ALU_OP_SLTU = 4'd8
    } alu_op_e;

    localparam logic [1:0] CIN_ZERO  = 2'd0;
    localparam logic [1:0] CIN_ONE   = 2'd1;
    localparam logic [1:0] CIN_CARRY = 2'd2;

endpackage

// File: rtl/alu_issue_decode.sv
// Opcode decoder for the ALU issue stage. SLT/SLTU decode only when
// ALU_ISSUE_SLT_EN is defined; otherwise those opcodes are illegal.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_sum_en,
    output logic       o_and_en,
    output logic       o_xor_en,
    output logic       o_invert_b,
    output logic [1:0] o_cin_sel,
    output logic       o_carry_upd,
    output logic       o_illegal
);

    // Opcode to ALU control mapping; OR is built from and+xor in the ALU.
    always_comb begin
        o_sum_en    = 1'b0;
        o_and_en    = 1'b0;
        o_xor_en    = 1'b0;
        o_invert_b  = 1'b0;
        o_cin_sel   = CIN_ZERO;
        o_carry_upd = 1'b0;
        o_illegal   = 1'b0;
        case (i_op)
            ALU_OP_ADD: begin
                o_sum_en    = 1'b1;
                o_carry_upd = 1'b1;
            end
            ALU_OP_SUB: begin
                o_sum_en    = 1'b1;
                o_invert_b  = 1'b1;
                o_cin_sel   = CIN_ONE;
                o_carry_upd = 1'b1;
            end
            ALU_OP_ADDC: begin
                o_sum_en    = 1'b1;
                o_cin_sel   = CIN_CARRY;
                o_carry_upd = 1'b1;
            end
            ALU_OP_SUBC: begin
                o_sum_en    = 1'b1;
                o_invert_b  = 1'b1;
                o_cin_sel   = CIN_CARRY;
                o_carry_upd = 1'b1;
            end
            ALU_OP_AND: begin
                o_and_en = 1'b1;
            end
            ALU_OP_OR: begin
                o_and_en = 1'b1;
                o_xor_en = 1'b1;
            end
            ALU_OP_XOR: begin
                o_xor_en = 1'b1;
            end
`ifdef ALU_ISSUE_SLT_EN
            ALU_OP_SLT, ALU_OP_SLTU: begin
                o_sum_en   = 1'b1;
                o_invert_b = 1'b1;
                o_cin_sel  = CIN_ONE;
            end
`endif
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/response front end for the combinational ALU, with a sticky
// carry for ADDC/SUBC chains. Define ALU_ISSUE_SLT_EN to build SLT/SLTU.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [2:0]      rsp_flags_o,
    output logic            rsp_err_o,
    output logic [XLEN-1:0] alu_inA_o,
    output logic [XLEN-1:0] alu_inB_o,
    output logic            alu_cflag_o,
    output logic            alu_sum_en_o,
    output logic            alu_and_en_o,
    output logic            alu_xor_en_o,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            alu_cflag_i,
    input  logic            alu_vflag_i,
    input  logic            alu_zflag_i
);

    logic            r_s1_valid;
    logic [3:0]      r_s1_op;
    logic [XLEN-1:0] r_s1_a;
    logic [XLEN-1:0] r_s1_b;
    logic            r_s2_valid;
    logic [XLEN-1:0] r_s2_data;
    logic [2:0]      r_s2_flags;
    logic            r_s2_err;
    logic            r_carry;

    logic            w_s1_adv;
    logic            w_accept;
    logic            w_sum_en;
    logic            w_and_en;
    logic            w_xor_en;
    logic            w_invert_b;
    logic [1:0]      w_cin_sel;
    logic            w_carry_upd;
    logic            w_illegal;
    logic [XLEN-1:0] w_result;
    logic [2:0]      w_flags;

    assign w_s1_adv    = r_s1_valid && (!r_s2_valid || rsp_ready_i);
    assign req_ready_o = !r_s1_valid || w_s1_adv;
    assign w_accept    = req_valid_i && req_ready_o;

    alu_issue_decode u_decode (
        .i_op        (r_s1_op),
        .o_sum_en    (w_sum_en),
        .o_and_en    (w_and_en),
        .o_xor_en    (w_xor_en),
        .o_invert_b  (w_invert_b),
        .o_cin_sel   (w_cin_sel),
        .o_carry_upd (w_carry_upd),
        .o_illegal   (w_illegal)
    );

    // ALU drive from S1; everything idles at zero when S1 is empty or illegal.
    always_comb begin
        alu_inA_o    = '0;
        alu_inB_o    = '0;
        alu_cflag_o  = 1'b0;
        alu_sum_en_o = 1'b0;
        alu_and_en_o = 1'b0;
        alu_xor_en_o = 1'b0;
        if (r_s1_valid && !w_illegal) begin
            alu_inA_o    = r_s1_a;
            alu_inB_o    = w_invert_b ? ~r_s1_b : r_s1_b;
            alu_sum_en_o = w_sum_en;
            alu_and_en_o = w_and_en;
            alu_xor_en_o = w_xor_en;
            case (w_cin_sel)
                CIN_ONE:   alu_cflag_o = 1'b1;
                CIN_CARRY: alu_cflag_o = r_carry;
                default:   alu_cflag_o = 1'b0;
            endcase
        end else begin
            alu_cflag_o = 1'b0;
        end
    end

    // Result selection; the compare results reuse the SUB drive of the ALU.
    always_comb begin
        w_result = alu_out_i;
        if (w_illegal) begin
            w_result = '0;
        end
`ifdef ALU_ISSUE_SLT_EN
        else if (r_s1_op == ALU_OP_SLT) begin
            w_result = {{(XLEN-1){1'b0}}, alu_out_i[XLEN-1] ^ alu_vflag_i};
        end else if (r_s1_op == ALU_OP_SLTU) begin
            w_result = {{(XLEN-1){1'b0}}, !alu_cflag_i};
        end
`endif
        else begin
            w_result = alu_out_i;
        end
    end

    // Flag packing into {C,V,Z}.
    always_comb begin
        w_flags         = 3'b000;
        w_flags[FLAG_C] = alu_cflag_i;
        w_flags[FLAG_V] = alu_vflag_i;
        w_flags[FLAG_Z] = alu_zflag_i;
    end

    // S1 operand register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 4'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= req_op_i;
            r_s1_a     <= req_a_i;
            r_s1_b     <= req_b_i;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 response register; holds its contents while the consumer stalls.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_flags <= 3'b000;
            r_s2_err   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_result;
            r_s2_flags <= w_flags;
            r_s2_err   <= w_illegal;
        end else if (rsp_ready_i) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Sticky carry, written as the op leaves S1 so a following ADDC sees it.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_carry <= 1'b0;
        end else if (w_s1_adv && w_carry_upd && !w_illegal) begin
            r_carry <= alu_cflag_i;
        end
    end

    assign rsp_valid_o = r_s2_valid;
    assign rsp_data_o  = r_s2_data;
    assign rsp_flags_o = r_s2_flags;
    assign rsp_err_o   = r_s2_err;

endmodule
